transform_sequencer: RTL

Drives the `transformer` handshake (`start`, `line`) so the design can play transforms without a human toggling `ui_in[6]`. In auto mode it walks lines 0..NUM_LINES-1, pausing a programmable dwell between lines. In manual mode it issues one validated request per rising edge of the start switch. It sits between the top-level `ui_in` decode and `transformer`, and it is the only driver of `transformer.start` and `transformer.line`.

---
 rtl/xf_pkg.sv | 32 +++
 rtl/dwell_timer.sv | 33 +++
 rtl/transform_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/xf_pkg.sv
// rtl/xf_pkg.sv - shared constants for the transform sequencer
package xf_pkg;

    localparam int NUM_LINES_DEF = 51;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK = 3'd2;
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_DWELL    = 3'd4;

    localparam logic [3:0] XF_IDLE = 4'd0;

    localparam int DWELL_W = 17;
    localparam logic [DWELL_W-1:0] DWELL_LEN_0 = 17'd2;
    localparam logic [DWELL_W-1:0] DWELL_LEN_1 = 17'd16;
    localparam logic [DWELL_W-1:0] DWELL_LEN_2 = 17'd256;
    localparam logic [DWELL_W-1:0] DWELL_LEN_3 = 17'd65536;

    // Counter reload value: the timer reaches zero after exactly len cycles.
    function automatic logic [DWELL_W-1:0] dwell_reload(input logic [1:0] sel);
        logic [DWELL_W-1:0] len;
        case (sel)
            2'd0:    len = DWELL_LEN_0;
            2'd1:    len = DWELL_LEN_1;
            2'd2:    len = DWELL_LEN_2;
            default: len = DWELL_LEN_3;
        endcase
        return len - DWELL_W'(1);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - loadable down-counter that parks at zero
module dwell_timer
    import xf_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_value_i,
    output logic               zero_o
);

    logic [DWELL_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (count_q != '0) begin
            count_d = count_q - DWELL_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/transform_sequencer.sv
// rtl/transform_sequencer.sv - drives the transformer start/line handshake
// in auto (line walk with dwell) or manual (switch edge) mode.
module transform_sequencer
    import xf_pkg::*;
#(
    parameter int NUM_LINES   = NUM_LINES_DEF,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       mode_auto_i,
    input  logic [5:0] manual_line_i,
    input  logic       manual_start_i,
    input  logic [1:0] div_sel_i,
    input  logic [3:0] xf_state_i,
    input  logic [9:0] xf_chars_remaining_i,
    output logic       xf_start_o,
    output logic [7:0] xf_line_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
    // err is registered, so the decision is taken one cycle early to land
    // the pulse ACK_TIMEOUT cycles after the start pulse.
    localparam int ACK_LAST = (ACK_TIMEOUT > 1) ? ACK_TIMEOUT - 2 : 0;
    localparam logic [ACK_W-1:0] ACK_LAST_C  = ACK_W'(ACK_LAST);
    localparam logic [5:0]       LAST_LINE   = 6'(NUM_LINES - 1);
    localparam logic [6:0]       NUM_LINES_C = 7'(NUM_LINES);

    logic [2:0]       state_q, state_d;
    logic [5:0]       cur_line_q, cur_line_d;
    logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
    logic             edge_q;
    logic             dwell_first_q, dwell_first_d;
    logic             xf_start_q;
    logic [7:0]       xf_line_q, xf_line_d;
    logic             busy_q;
    logic             err_q, err_d;

    logic manual_rise;
    logic line_ok;
    logic xf_done;
    logic dwell_load;
    logic dwell_zero;

    assign manual_rise = manual_start_i & ~edge_q;
    assign line_ok     = ({1'b0, manual_line_i} < NUM_LINES_C);
    assign xf_done     = (xf_state_i == XF_IDLE) && (xf_chars_remaining_i == '0);

    dwell_timer u_dwell_timer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (dwell_load),
        .load_value_i (dwell_reload(div_sel_i)),
        .zero_o       (dwell_zero)
    );

    always_comb begin
        state_d       = state_q;
        cur_line_d    = cur_line_q;
        ack_cnt_d     = ack_cnt_q;
        dwell_first_d = 1'b0;
        dwell_load    = 1'b0;
        err_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mode_auto_i) begin
                    cur_line_d = '0;
                    state_d    = ST_START;
                end else if (manual_rise) begin
                    if (line_ok) begin
                        cur_line_d = manual_line_i;
                        state_d    = ST_START;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_START: begin
                ack_cnt_d = '0;
                state_d   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (xf_state_i != XF_IDLE) begin
                    state_d = ST_RUN;
                end else if (ack_cnt_q == ACK_LAST_C) begin
                    err_d         = 1'b1;
                    dwell_first_d = 1'b1;
                    state_d       = ST_DWELL;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_W'(1);
                end
            end
            ST_RUN: begin
                if (xf_done) begin
                    if (mode_auto_i) begin
                        dwell_first_d = 1'b1;
                        state_d       = ST_DWELL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DWELL: begin
                // The first DWELL cycle only loads the timer; zero is stale there.
                if (dwell_first_q) begin
                    dwell_load = 1'b1;
                end else if (dwell_zero) begin
                    if (mode_auto_i) begin
                        cur_line_d = (cur_line_q == LAST_LINE) ? 6'd0 : cur_line_q + 6'd1;
                        state_d    = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign xf_line_d = (state_d == ST_START) ? {2'b00, cur_line_d} : xf_line_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cur_line_q    <= '0;
            ack_cnt_q     <= '0;
            edge_q        <= 1'b0;
            dwell_first_q <= 1'b0;
            xf_start_q    <= 1'b0;
            xf_line_q     <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_line_q    <= cur_line_d;
            ack_cnt_q     <= ack_cnt_d;
            edge_q        <= manual_start_i;
            dwell_first_q <= dwell_first_d;
            xf_start_q    <= (state_d == ST_START);
            xf_line_q     <= xf_line_d;
            busy_q        <= (state_d != ST_IDLE);
            err_q         <= err_d;
        end
    end

    assign xf_start_o = xf_start_q;
    assign xf_line_o  = xf_line_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;

endmodule
